prng_seq_ctrl: RTL and testbench

- Sequencer wrapped around the Park-Miller prng core (Schrage method, shared divider).
- Selects one of four seeds, configures a/m, and issues prng starts with a clean done handshake.
- Chains each result back in as the next seed, for a programmed count or free-running until stop.
- Hands each number to the parallel-to-serial (p2s) converter over a valid/ready handshake; watchdog flags a hung core.

---
 rtl/prng_pkg.sv | 34 +++
 rtl/prng_watchdog.sv | 28 ++
 rtl/prng_seq_ctrl.sv | 114 +++++++++++
 tb/tb_prng_seq_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared constants for the Park-Miller sequencer: FSM encodings, default seeds
// and the multiplier/modulus driven to the core.
package prng_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_PUSH   = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  localparam logic [31:0] DEF_SEED0   = 32'd5;
  localparam logic [31:0] DEF_SEED1   = 32'd7;
  localparam logic [31:0] DEF_SEED2   = 32'd9;
  localparam logic [31:0] DEF_SEED3   = 32'd11;
  localparam logic [31:0] DEF_PARAM_A = 32'd16807;
  localparam logic [31:0] DEF_PARAM_M = 32'h7FFF_FFFF;

  function automatic logic [31:0] seed_pick(input logic [1:0]  sel,
                                            input logic [31:0] s0,
                                            input logic [31:0] s1,
                                            input logic [31:0] s2,
                                            input logic [31:0] s3);
    logic [31:0] r;
    case (sel)
      2'd0:    r = s0;
      2'd1:    r = s1;
      2'd2:    r = s2;
      default: r = s3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/prng_watchdog.sv
// Loadable down-counter; flags a timeout once it has counted TIMEOUT enabled
// cycles since the last load.
module prng_watchdog #(
  parameter int TIMEOUT = 1024,
  localparam int W      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic timeout
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(TIMEOUT - 1);
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign timeout = en && (cnt == '0);

endmodule

// File: rtl/prng_seq_ctrl.sv
// Sequencer around a Park-Miller core: seeds it, chains each result back as
// the next seed, and streams results to the p2s converter.
module prng_seq_ctrl
  import prng_pkg::*;
#(
  parameter logic [31:0] SEED0   = DEF_SEED0,
  parameter logic [31:0] SEED1   = DEF_SEED1,
  parameter logic [31:0] SEED2   = DEF_SEED2,
  parameter logic [31:0] SEED3   = DEF_SEED3,
  parameter logic [31:0] PARAM_A = DEF_PARAM_A,
  parameter logic [31:0] PARAM_M = DEF_PARAM_M,
  parameter int          CNT_W   = 16,
  parameter int          TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       sel,
  input  logic [CNT_W-1:0] num,
  input  logic             prng_done,
  input  logic [31:0]      prng_rand,
  output logic             prng_start,
  output logic [31:0]      prng_seed,
  output logic [31:0]      prng_a,
  output logic [31:0]      prng_m,
  input  logic             p2s_ready,
  output logic             p2s_valid,
  output logic [31:0]      p2s_data,
  output logic [31:0]      seed,
  output logic             busy,
  output logic             run_done,
  output logic             err
);

  logic [2:0]       state;
  logic [CNT_W-1:0] remaining;
  logic             free;
  logic             stop_pend;
  logic             wd_timeout;
  logic [31:0]      seed_sel;

  assign seed_sel   = seed_pick(sel, SEED0, SEED1, SEED2, SEED3);
  assign prng_a     = PARAM_A;
  assign prng_m     = PARAM_M;
  assign prng_start = (state == ST_ISSUE);
  assign busy       = (state != ST_IDLE);
  assign run_done   = (state == ST_FINISH);

  // Watchdog only counts while the core owes us a result, never during PUSH.
  prng_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .load    (state == ST_ISSUE),
    .en      (state == ST_WAIT),
    .timeout (wd_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      seed      <= '0;
      prng_seed <= '0;
      p2s_data  <= '0;
      p2s_valid <= 1'b0;
      err       <= 1'b0;
      remaining <= '0;
      free      <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      if (stop && state != ST_IDLE) stop_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            seed      <= seed_sel;
            prng_seed <= seed_sel;
            remaining <= num;
            free      <= (num == '0);
            err       <= 1'b0;
            stop_pend <= 1'b0;
            state     <= ST_CLEAR;
          end
        end
        // The core keeps done high from the previous number; wait it out.
        ST_CLEAR: if (!prng_done) state <= ST_ISSUE;
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (prng_done) begin
            p2s_data  <= prng_rand;
            prng_seed <= prng_rand;
            p2s_valid <= 1'b1;
            state     <= ST_PUSH;
          end else if (wd_timeout) begin
            err   <= 1'b1;
            state <= ST_FINISH;
          end
        end
        ST_PUSH: begin
          if (p2s_ready) begin
            p2s_valid <= 1'b0;
            if (!free) remaining <= remaining - 1'b1;
            if ((!free && remaining == CNT_W'(1)) || stop_pend || stop)
              state <= ST_FINISH;
            else
              state <= ST_CLEAR;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prng_seq_ctrl.sv
// Scoreboard bench for prng_seq_ctrl with a behavioural Park-Miller core model.
module tb_prng_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [15:0] num = 16'd0;
  logic        prng_done = 1'b0;
  logic [31:0] prng_rand = 32'd0;
  logic        prng_start;
  logic [31:0] prng_seed, prng_a, prng_m;
  logic        p2s_ready = 1'b1;
  logic        p2s_valid;
  logic [31:0] p2s_data, seed;
  logic        busy, run_done, err;

  prng_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sel(sel), .num(num),
    .prng_done(prng_done), .prng_rand(prng_rand), .prng_start(prng_start),
    .prng_seed(prng_seed), .prng_a(prng_a), .prng_m(prng_m),
    .p2s_ready(p2s_ready), .p2s_valid(p2s_valid), .p2s_data(p2s_data),
    .seed(seed), .busy(busy), .run_done(run_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_start = 0;
  int n_rdone = 0;
  int n_acc = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] pm_next(input logic [31:0] s);
    longint unsigned p;
    p = longint'(s) * 64'd16807;
    return 32'(p % 64'd2147483647);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endfunction

  // Core model: result after lat cycles, done then held for hold cycles.
  int          lat = 3;
  int          hold = 2;
  bit          never_done = 0;
  int          cnt = 0;
  int          hcnt = 0;
  bit          pending = 0;
  logic [31:0] seed_l = 32'd0;

  always @(posedge clk) begin
    if (prng_start) begin
      pending <= 1'b1;
      cnt     <= lat;
      seed_l  <= prng_seed;
    end else if (pending) begin
      if (cnt <= 1) begin
        pending <= 1'b0;
        if (!never_done) begin
          prng_done <= 1'b1;
          prng_rand <= 32'((longint'(seed_l) * longint'(prng_a)) % longint'(prng_m));
          hcnt      <= hold;
        end
      end else begin
        cnt <= cnt - 1;
      end
    end else if (prng_done) begin
      if (hcnt == 0) prng_done <= 1'b0;
      else hcnt <= hcnt - 1;
    end
  end

  // Monitor: pops the scoreboard on every accepted word.
  always @(negedge clk) begin
    if (prng_start) n_start++;
    if (run_done) n_rdone++;
    if (!rst && p2s_valid && p2s_ready) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got %0d required none", p2s_data);
      end else begin
        chk("p2s_data", p2s_data, exp_q.pop_front());
      end
    end
  end

  task automatic do_start(input logic [1:0] s, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; sel = s; num = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    n_chk++; n_fail++;
    $display("FAIL wait_idle_timeout: got busy=1 required busy=0 within %0d cycles", budget);
  endtask

  int b_start, b_done, b_acc;
  bit ok;
  bit seen;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", p2s_valid, 0);
    chk("rst_run_done", run_done, 0);
    chk("rst_err", err, 0);
    chk("rst_prng_start", prng_start, 0);
    chk("rst_seed", seed, 0);
    chk("rst_prng_seed", prng_seed, 0);
    chk("rst_p2s_data", p2s_data, 0);
    chk("rst_prng_a", prng_a, 32'd16807);
    chk("rst_prng_m", prng_m, 32'h7FFFFFFF);
    rst = 1'b0;

    // sel=0, num=3
    exp_q.push_back(32'd84035);
    exp_q.push_back(32'd1412376245);
    exp_q.push_back(32'd1670799424);
    b_start = n_start; b_done = n_rdone;
    do_start(2'd0, 16'd3);
    wait_idle(300);
    chk("t1_seed", seed, 32'd5);
    chk("t1_run_done_cnt", n_rdone - b_done, 1);
    chk("t1_start_cnt", n_start - b_start, 3);
    chk("t1_queue_empty", exp_q.size(), 0);

    // sel=1, num=1
    exp_q.push_back(32'd117649);
    b_start = n_start;
    do_start(2'd1, 16'd1);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (run_done) seen = 1;
    end
    chk("t2_run_done_seen", seen, 1);
    @(negedge clk);
    chk("t2_busy_after_done", busy, 0);
    chk("t2_run_done_one_cycle", run_done, 0);
    chk("t2_start_cnt", n_start - b_start, 1);
    chk("t2_seed", seed, 32'd7);

    // sel=0, num=2 with p2s stalled on the first word
    p2s_ready = 1'b0;
    exp_q.push_back(32'd84035);
    exp_q.push_back(pm_next(32'd84035));
    b_start = n_start;
    do_start(2'd0, 16'd2);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (p2s_valid) seen = 1;
    end
    chk("t3_valid_seen", seen, 1);
    ok = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!p2s_valid || p2s_data !== 32'd84035 || n_start - b_start != 1) ok = 0;
    end
    chk("t3_stall_hold", ok, 1);
    chk("t3_err", err, 0);
    p2s_ready = 1'b1;
    wait_idle(300);
    chk("t3_start_cnt", n_start - b_start, 2);
    chk("t3_err_end", err, 0);

    // Free-run with stop raised after the 3rd acceptance: the 4th completes.
    exp_q.push_back(32'd84035);
    exp_q.push_back(32'd1412376245);
    exp_q.push_back(32'd1670799424);
    exp_q.push_back(pm_next(32'd1670799424));
    b_acc = n_acc; b_done = n_rdone;
    do_start(2'd0, 16'd0);
    for (int i = 0; i < 300 && (n_acc - b_acc) < 3; i++) @(negedge clk);
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_idle(300);
    chk("t4_words", n_acc - b_acc, 4);
    chk("t4_run_done_cnt", n_rdone - b_done, 1);
    chk("t4_queue_empty", exp_q.size(), 0);

    // Core never answers: watchdog fires after TIMEOUT cycles in WAIT.
    never_done = 1;
    b_acc = n_acc; b_done = n_rdone;
    do_start(2'd0, 16'd1);
    repeat (1000) @(negedge clk);
    chk("t5_err_early", err, 0);
    chk("t5_busy_early", busy, 1);
    wait_idle(200);
    chk("t5_err", err, 1);
    chk("t5_run_done_cnt", n_rdone - b_done, 1);
    chk("t5_no_words", n_acc - b_acc, 0);
    never_done = 0;

    // rst during WAIT drops the run; a new sel=2 run then works.
    lat = 10;
    do_start(2'd0, 16'd1);
    chk("t6_err_cleared", err, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", p2s_valid, 0);
    rst = 1'b0;
    repeat (25) @(posedge clk);
    lat = 3;
    exp_q.push_back(32'd151263);
    do_start(2'd2, 16'd1);
    wait_idle(300);
    chk("t6_seed", seed, 32'd9);
    chk("t6_queue_empty", exp_q.size(), 0);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
